// File: rtl/fpnew_pkg.sv
// Shared FPU types: IEEE status flags and arbiter-wide constants.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package fpnew_pkg;

  // IEEE-754 exception flags reported with every result.
  typedef struct packed {
    logic NV;  // invalid
    logic DZ;  // divide by zero
    logic OF;  // overflow
    logic UF;  // underflow
    logic NX;  // inexact
  } status_t;

  // Width of the output backpressure counter.
  localparam int unsigned STALL_CNT_WIDTH = 16;

endpackage

// File: rtl/fpnew_rr_arbiter.sv
// Round-robin arbiter: first valid input at or above the priority pointer wins.
// Latency: purely combinational, no state.
// Backpressure: none; the caller gates the grant with its own readiness.
module fpnew_rr_arbiter #(
  parameter  int unsigned NumIn = 4,
  localparam int unsigned IdxW  = $clog2(NumIn)
) (
  input  logic [NumIn-1:0] valid,
  input  logic [IdxW-1:0]  ptr,
  output logic [NumIn-1:0] grant,
  output logic [IdxW-1:0]  idx,
  output logic             gnt_vld
);

  localparam int N = NumIn;

  int              cand;
  logic [IdxW-1:0] cidx;

  // Scan downward so the last hit written is the closest one to ptr.
  always_comb begin
    grant   = '0;
    idx     = '0;
    gnt_vld = 1'b0;
    cand    = 0;
    cidx    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = (int'(ptr) + k) % N;
      cidx = cand[IdxW-1:0];
      if (valid[cidx]) begin
        idx     = cidx;
        gnt_vld = 1'b1;
      end
    end
    if (gnt_vld) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/fpnew_slice_result_arbiter.sv
// Round-robin collector of per-slice FPU results into a 2-entry output FIFO.
// Latency: a result accepted in cycle N appears on the outputs in cycle N+1.
// Backpressure: slice ready drops while the FIFO is full (registered count), during flush_i and rst_i.
// Optional stall counter: define FPNEW_ARB_STALL_CNT_EN.
module fpnew_slice_result_arbiter
  import fpnew_pkg::*;
#(
  parameter int unsigned NumSlices = 4,
  parameter int unsigned Width     = 32,
  parameter type         TagType   = logic,
  parameter int unsigned Depth     = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NumSlices-1:0][Width-1:0]   slice_result_i,
  input  status_t [NumSlices-1:0]           slice_status_i,
  input  logic [NumSlices-1:0]              slice_ext_bit_i,
  input  TagType [NumSlices-1:0]            slice_tag_i,
  input  logic [NumSlices-1:0]              slice_valid_i,
  output logic [NumSlices-1:0]              slice_ready_o,
  input  logic                              flush_i,
  output logic [Width-1:0]                  result_o,
  output status_t                           status_o,
  output logic                              extension_bit_o,
  output TagType                            tag_o,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic                              busy_o,
  output logic [STALL_CNT_WIDTH-1:0]        stall_cnt_o
);

  localparam int unsigned IdxW = $clog2(NumSlices);
  localparam int unsigned CntW = $clog2(Depth + 1);

  // The entry is width-parameterised, so it is declared alongside the module.
  // The tag travels in its own registers because its type is a parameter.
  typedef struct packed {
    logic [Width-1:0] result;
    status_t          status;
    logic             ext_bit;
  } arb_entry_t;

  logic [IdxW-1:0]      prio_q;
  logic [IdxW-1:0]      gnt_idx;
  logic [IdxW-1:0]      prio_next;
  logic [NumSlices-1:0] grant;
  logic                 gnt_vld;

  logic [CntW-1:0]      cnt_q;
  arb_entry_t           head_q, tail_q;
  TagType               head_tag_q, tail_tag_q;

  arb_entry_t           in_entry;
  TagType               in_tag;
  logic                 full, accept_ok, push, pop;

  fpnew_rr_arbiter #(
    .NumIn (NumSlices)
  ) u_rr (
    .valid   (slice_valid_i),
    .ptr     (prio_q),
    .grant   (grant),
    .idx     (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  // Readiness depends only on registered fullness, so a pop never frees a slot in the same cycle.
  assign full          = (cnt_q == CntW'(Depth));
  assign accept_ok     = ~full & ~flush_i & ~rst_i;
  assign slice_ready_o = grant & {NumSlices{accept_ok}};
  assign push          = gnt_vld & accept_ok;
  assign pop           = out_valid_o & out_ready_i & ~flush_i;

  assign in_entry = '{result:  slice_result_i[gnt_idx],
                      status:  slice_status_i[gnt_idx],
                      ext_bit: slice_ext_bit_i[gnt_idx]};
  assign in_tag   = slice_tag_i[gnt_idx];

  assign prio_next = (gnt_idx == IdxW'(NumSlices - 1)) ? '0 : gnt_idx + IdxW'(1);

  // Priority moves just past the winner on every accept; flush leaves it alone.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q <= '0;
    end else if (push) begin
      prio_q <= prio_next;
    end
  end

  // Two-slot FIFO: head_q is the output register, tail_q holds the second entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      head_tag_q <= '0;
      tail_tag_q <= '0;
    end else if (flush_i) begin
      cnt_q <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_q == '0) begin
            head_q     <= in_entry;
            head_tag_q <= in_tag;
          end else begin
            tail_q     <= in_entry;
            tail_tag_q <= in_tag;
          end
          cnt_q <= cnt_q + CntW'(1);
        end
        2'b01: begin
          // With one entry left the head simply holds its last value.
          if (full) begin
            head_q     <= tail_q;
            head_tag_q <= tail_tag_q;
          end
          cnt_q <= cnt_q - CntW'(1);
        end
        2'b11: begin
          // Only reachable with one entry: replace the head, count unchanged.
          head_q     <= in_entry;
          head_tag_q <= in_tag;
        end
        default: ;
      endcase
    end
  end

  assign out_valid_o     = (cnt_q != '0);
  assign result_o        = head_q.result;
  assign status_o        = head_q.status;
  assign extension_bit_o = head_q.ext_bit;
  assign tag_o           = head_tag_q;
  assign busy_o          = out_valid_o | (|slice_valid_i);

`ifdef FPNEW_ARB_STALL_CNT_EN
  logic [STALL_CNT_WIDTH-1:0] stall_q;

  // Count cycles where a result waits on downstream; saturate rather than wrap.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      stall_q <= '0;
    end else if (out_valid_o && !out_ready_i && (stall_q != '1)) begin
      stall_q <= stall_q + STALL_CNT_WIDTH'(1);
    end
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fpnew_slice_result_arbiter.sv
// Self-checking bench for fpnew_slice_result_arbiter: directed vector table,
// stall counter sequence, then randomized traffic against a queue-based model.
module tb_fpnew_slice_result_arbiter;
  import fpnew_pkg::*;

  typedef logic [3:0] tag_t;

  typedef struct packed {
    logic [31:0] r;
    status_t     s;
    logic        e;
    tag_t        t;
  } pay_t;

  typedef struct {
    logic       rst;
    logic       flush;
    logic [3:0] vld;
    logic       ordy;
    logic [3:0] e_rdy;
    logic       e_ov;
    int         e_src;   // slice whose fixed data is on the outputs, -1 = zeros
    logic       e_busy;
  } vec_t;

  logic                  clk = 1'b0;
  logic                  rst, flush, out_ready;
  logic [3:0][31:0]      s_res;
  status_t [3:0]         s_stat;
  logic [3:0]            s_ext;
  tag_t [3:0]            s_tag;
  logic [3:0]            s_vld;
  logic [3:0]            s_rdy;
  logic [31:0]           res;
  status_t               stat;
  logic                  ext;
  tag_t                  tag;
  logic                  ov, busy;
  logic [15:0]           stall;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] res_c [4] = '{32'h4000_0000, 32'h3F80_0000, 32'h4040_0000, 32'h4080_0000};

  fpnew_slice_result_arbiter #(
    .NumSlices (4),
    .Width     (32),
    .TagType   (tag_t),
    .Depth     (2)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .slice_result_i  (s_res),
    .slice_status_i  (s_stat),
    .slice_ext_bit_i (s_ext),
    .slice_tag_i     (s_tag),
    .slice_valid_i   (s_vld),
    .slice_ready_o   (s_rdy),
    .flush_i         (flush),
    .result_o        (res),
    .status_o        (stat),
    .extension_bit_o (ext),
    .tag_o           (tag),
    .out_valid_o     (ov),
    .out_ready_i     (out_ready),
    .busy_o          (busy),
    .stall_cnt_o     (stall)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic f, input logic [3:0] v, input logic o,
                              input logic [3:0] er, input logic eov, input int src, input logic eb);
    vec_t x;
    x.rst = r; x.flush = f; x.vld = v; x.ordy = o;
    x.e_rdy = er; x.e_ov = eov; x.e_src = src; x.e_busy = eb;
    return x;
  endfunction

  function automatic pay_t fixed_pay(input int src);
    pay_t p;
    if (src < 0) return '0;
    p.r = res_c[src];
    p.s = status_t'(5'(src + 1));
    p.e = 1'(src);
    p.t = tag_t'(src);
    return p;
  endfunction

  function automatic logic [15:0] stall_exp(input int unsigned m);
`ifdef FPNEW_ARB_STALL_CNT_EN
    return 16'(m);
`else
    return (m == 0) ? 16'h0 : 16'h0;
`endif
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t        tbl[$];
    pay_t        mq[$];
    pay_t        shown, cur;
    int          mp, win, j;
    int unsigned mstall;
    logic [3:0]  pend, exp_rdy;
    logic        exp_ov, exp_busy;

    // cycle-by-cycle directed table: single slice, fairness, backpressure, flush, reset
    tbl.push_back(mk(1, 0, 4'b0000, 0, 4'b0000, 0, -1, 0));
    tbl.push_back(mk(0, 0, 4'b0010, 1, 4'b0010, 0, -1, 1));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 4'b0000, 1,  1, 1));
    tbl.push_back(mk(0, 0, 4'b0000, 0, 4'b0000, 0,  1, 0));
    tbl.push_back(mk(0, 0, 4'b1000, 1, 4'b1000, 0,  1, 1));
    tbl.push_back(mk(0, 0, 4'b1111, 1, 4'b0001, 1,  3, 1));
    tbl.push_back(mk(0, 0, 4'b1111, 1, 4'b0010, 1,  0, 1));
    tbl.push_back(mk(0, 0, 4'b1111, 1, 4'b0100, 1,  1, 1));
    tbl.push_back(mk(0, 0, 4'b1111, 1, 4'b1000, 1,  2, 1));
    tbl.push_back(mk(0, 0, 4'b1111, 1, 4'b0001, 1,  3, 1));
    tbl.push_back(mk(0, 0, 4'b1000, 1, 4'b1000, 1,  0, 1));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 4'b0000, 1,  3, 1));
    tbl.push_back(mk(0, 0, 4'b0101, 0, 4'b0001, 0,  3, 1));
    tbl.push_back(mk(0, 0, 4'b0100, 0, 4'b0100, 1,  0, 1));
    tbl.push_back(mk(0, 0, 4'b0001, 0, 4'b0000, 1,  0, 1));
    tbl.push_back(mk(0, 0, 4'b0001, 1, 4'b0000, 1,  0, 1));
    tbl.push_back(mk(0, 0, 4'b0001, 1, 4'b0001, 1,  2, 1));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 4'b0000, 1,  0, 1));
    tbl.push_back(mk(0, 0, 4'b0110, 0, 4'b0010, 0,  0, 1));
    tbl.push_back(mk(0, 0, 4'b0100, 0, 4'b0100, 1,  1, 1));
    tbl.push_back(mk(0, 1, 4'b0000, 1, 4'b0000, 1,  1, 1));
    tbl.push_back(mk(0, 0, 4'b0000, 0, 4'b0000, 0,  1, 0));
    tbl.push_back(mk(0, 1, 4'b1000, 0, 4'b0000, 0,  1, 1));
    tbl.push_back(mk(0, 0, 4'b1000, 0, 4'b1000, 0,  1, 1));
    tbl.push_back(mk(0, 0, 4'b0001, 0, 4'b0001, 1,  3, 1));
    tbl.push_back(mk(1, 0, 4'b0010, 0, 4'b0000, 1,  3, 1));
    tbl.push_back(mk(0, 0, 4'b1111, 0, 4'b0001, 0, -1, 1));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 4'b0000, 1,  0, 1));
    tbl.push_back(mk(0, 0, 4'b0000, 0, 4'b0000, 0,  0, 0));

    for (int i = 0; i < 4; i++) begin
      s_res[i]  = res_c[i];
      s_stat[i] = status_t'(5'(i + 1));
      s_ext[i]  = 1'(i);
      s_tag[i]  = tag_t'(i);
    end
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; s_vld = '0;
    next_cycle();

    for (int r = 0; r < tbl.size(); r++) begin
      rst = tbl[r].rst; flush = tbl[r].flush; s_vld = tbl[r].vld; out_ready = tbl[r].ordy;
      #4;
      chk($sformatf("row%0d ready", r), 64'(s_rdy), 64'(tbl[r].e_rdy));
      chk($sformatf("row%0d out_valid", r), 64'(ov), 64'(tbl[r].e_ov));
      chk($sformatf("row%0d payload", r), 64'({res, stat, ext, tag}), 64'(fixed_pay(tbl[r].e_src)));
      chk($sformatf("row%0d busy", r), 64'(busy), 64'(tbl[r].e_busy));
      if (r == 0) chk("reset stall_cnt", 64'(stall), 64'h0);
      next_cycle();
    end

    // stall counter: flush clears it, then 5 cycles of valid without ready
    rst = 1'b0; flush = 1'b1; s_vld = '0; out_ready = 1'b0;
    next_cycle();
    flush = 1'b0; s_vld = 4'b0001;
    #4;
    chk("stall after flush", 64'(stall), 64'(stall_exp(0)));
    chk("stall push ready", 64'(s_rdy), 64'h1);
    next_cycle();
    s_vld = '0;
    for (int c = 0; c < 5; c++) next_cycle();
    #4;
    chk("stall count 5", 64'(stall), 64'(stall_exp(5)));
    chk("stall out_valid", 64'(ov), 64'h1);
    next_cycle();
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    #4;
    chk("stall cleared by flush", 64'(stall), 64'(stall_exp(0)));
    next_cycle();

    // randomized traffic vs. queue model; start from a clean reset
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    mq.delete(); mp = 0; shown = '0; mstall = 0; pend = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(2) == 0) begin
          pend[i]   = 1'b1;
          s_res[i]  = $urandom;
          s_stat[i] = status_t'(5'($urandom));
          s_ext[i]  = 1'($urandom);
          s_tag[i]  = tag_t'($urandom);
        end
      end
      s_vld     = pend;
      out_ready = ((cyc / 200) % 2 == 1) ? ($urandom_range(3) == 0) : ($urandom_range(9) != 0);
      flush     = ($urandom_range(40) == 0);
      rst       = ($urandom_range(150) == 0);

      exp_ov = (mq.size() != 0);
      if (exp_ov) shown = mq[0];
      win = -1;
      if (!rst && !flush && mq.size() < 2) begin
        for (int k = 0; k < 4; k++) begin
          j = (mp + k) % 4;
          if (win < 0 && s_vld[j]) win = j;
        end
      end
      exp_rdy = '0;
      if (win >= 0) exp_rdy[win] = 1'b1;
      exp_busy = exp_ov || (|s_vld);

      #4;
      chk("rand ready", 64'(s_rdy), 64'(exp_rdy));
      chk("rand out_valid", 64'(ov), 64'(exp_ov));
      chk("rand payload", 64'({res, stat, ext, tag}), 64'(shown));
      chk("rand busy", 64'(busy), 64'(exp_busy));
      chk("rand stall_cnt", 64'(stall), 64'(stall_exp(mstall)));

      if (rst) begin
        mq.delete(); mp = 0; shown = '0; mstall = 0;
      end else if (flush) begin
        mq.delete(); mstall = 0;
      end else begin
        if (exp_ov && !out_ready && mstall < 65535) mstall++;
        if (exp_ov && out_ready) void'(mq.pop_front());
        if (win >= 0) begin
          cur.r = s_res[win]; cur.s = s_stat[win]; cur.e = s_ext[win]; cur.t = s_tag[win];
          mq.push_back(cur);
          mp = (win + 1) % 4;
          pend[win] = 1'b0;
        end
      end
      next_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
